// File: rtl/pong_pkg.sv
// Shared playfield constants, FSM state type and signed helpers for the
// paddle and ball blocks.
package pong_pkg;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int PADDLE_W   = 16;
  localparam int PADDLE_H   = 80;
  localparam int L_POSITION = 20;
  localparam int R_POSITION = 20;

  typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_e;

  typedef logic signed [10:0] s11_t;

  function automatic s11_t to_s11(input logic [9:0] v);
    return signed'({1'b0, v});
  endfunction

  function automatic s11_t abs11(input s11_t v);
    return v[10] ? -v : v;
  endfunction
endpackage

// File: rtl/ball_ctrl_if.sv
// Pixel/paddle inputs and ball/score outputs of the ball controller.
interface ball_ctrl_if;
  logic [9:0]  x, y;
  logic [9:0]  x_paddle1, y_paddle1, x_paddle2, y_paddle2;
  logic [9:0]  x_ball, y_ball;
  logic        ball_on;
  logic [11:0] rgb_ball;
  logic [3:0]  score1, score2;
  logic        game_over;

  modport master (
    output x, y, x_paddle1, y_paddle1, x_paddle2, y_paddle2,
    input  x_ball, y_ball, ball_on, rgb_ball, score1, score2, game_over
  );

  modport slave (
    input  x, y, x_paddle1, y_paddle1, x_paddle2, y_paddle2,
    output x_ball, y_ball, ball_on, rgb_ball, score1, score2, game_over
  );
endinterface

// File: rtl/score_counter.sv
// 4-bit saturating point counter with synchronous reset.
module score_counter #(
  parameter int unsigned MAX = 9
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  output logic [3:0] count_o
);
  logic [3:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != 4'(MAX))) begin
      count_q <= count_q + 4'd1;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/ball_ctrl.sv
// Pong ball: serve delay, 1 px/tick motion, wall and paddle bounces,
// miss scoring and game-over hold.
module ball_ctrl #(
  parameter int H_ACTIVE    = pong_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = pong_pkg::V_ACTIVE,
  parameter int BALL_SIZE   = 8,
  parameter int SERVE_DELAY = 1000,
  parameter int WIN_SCORE   = 9
) (
  input  logic        clk_1ms,
  input  logic        reset,
  ball_ctrl_if.slave  bus
);
  import pong_pkg::state_e;
  import pong_pkg::s11_t;
  import pong_pkg::to_s11;
  import pong_pkg::abs11;

  localparam int         CNT_W   = $clog2(SERVE_DELAY + 1);
  localparam s11_t       HALF    = s11_t'(BALL_SIZE / 2);
  localparam s11_t       HALF_M1 = s11_t'(BALL_SIZE / 2 - 1);
  localparam s11_t       X_MAX   = s11_t'(H_ACTIVE - 1);
  localparam s11_t       Y_MAX   = s11_t'(V_ACTIVE - 1);
  localparam s11_t       P_REACH = s11_t'(pong_pkg::PADDLE_W / 2 + 1);
  localparam s11_t       P_SPAN  = s11_t'((pong_pkg::PADDLE_H + BALL_SIZE) / 2);
  localparam logic [9:0] X_C     = 10'(H_ACTIVE / 2);
  localparam logic [9:0] Y_C     = 10'(V_ACTIVE / 2);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       xb_q, yb_q;
  logic             dx_q, dy_q, p1_pt_q;
  logic [3:0]       score1, score2;

  s11_t xb, yb, xs, ys;
  logic wall_hit, hit1, hit2, miss_l, miss_r, ndx, ndy, win1, win2;

  assign xb = to_s11(xb_q);
  assign yb = to_s11(yb_q);
  assign xs = to_s11(bus.x);
  assign ys = to_s11(bus.y);

  assign wall_hit = ((yb - HALF == '0) && !dy_q) || ((yb + HALF == Y_MAX) && dy_q);
  assign hit1 = !dx_q && (xb - HALF == to_s11(bus.x_paddle1) + P_REACH) &&
                (abs11(yb - to_s11(bus.y_paddle1)) < P_SPAN);
  assign hit2 = dx_q && (xb + HALF == to_s11(bus.x_paddle2) - P_REACH) &&
                (abs11(yb - to_s11(bus.y_paddle2)) < P_SPAN);
  assign miss_l = !dx_q && (xb - HALF == '0);
  assign miss_r = dx_q && (xb + HALF == X_MAX);
  assign ndx    = dx_q ^ (hit1 | hit2);
  assign ndy    = dy_q ^ wall_hit;
  assign win1   = (score1 == 4'(WIN_SCORE - 1));
  assign win2   = (score2 == 4'(WIN_SCORE - 1));

  always_ff @(posedge clk_1ms) begin
    if (reset) begin
      state_q <= pong_pkg::SERVE;
      cnt_q   <= '0;
      xb_q    <= X_C;
      yb_q    <= Y_C;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      p1_pt_q <= 1'b0;
    end else begin
      case (state_q)
        pong_pkg::SERVE: begin
          xb_q <= X_C;
          yb_q <= Y_C;
          if (cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
            cnt_q   <= '0;
            state_q <= pong_pkg::PLAY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        pong_pkg::PLAY: begin
          // A miss freezes the ball and directions; POINT applies the serve-side changes.
          if (miss_l || miss_r) begin
            p1_pt_q <= miss_r;
            state_q <= pong_pkg::POINT;
          end else begin
            dx_q <= ndx;
            dy_q <= ndy;
            xb_q <= ndx ? xb_q + 10'd1 : xb_q - 10'd1;
            yb_q <= ndy ? yb_q + 10'd1 : yb_q - 10'd1;
          end
        end
        pong_pkg::POINT: begin
          xb_q    <= X_C;
          yb_q    <= Y_C;
          dx_q    <= p1_pt_q;
          dy_q    <= ~dy_q;
          state_q <= (p1_pt_q ? win1 : win2) ? pong_pkg::OVER : pong_pkg::SERVE;
        end
        pong_pkg::OVER: begin
          xb_q <= X_C;
          yb_q <= Y_C;
        end
      endcase
    end
  end

  score_counter #(.MAX(WIN_SCORE)) u_score1 (
    .clk_i   (clk_1ms),
    .rst_i   (reset),
    .inc_i   ((state_q == pong_pkg::POINT) && p1_pt_q),
    .count_o (score1)
  );

  score_counter #(.MAX(WIN_SCORE)) u_score2 (
    .clk_i   (clk_1ms),
    .rst_i   (reset),
    .inc_i   ((state_q == pong_pkg::POINT) && !p1_pt_q),
    .count_o (score2)
  );

  assign bus.x_ball    = xb_q;
  assign bus.y_ball    = yb_q;
  assign bus.score1    = score1;
  assign bus.score2    = score2;
  assign bus.game_over = (state_q == pong_pkg::OVER);
  assign bus.rgb_ball  = 12'hFFF;
  assign bus.ball_on   = (state_q != pong_pkg::OVER) &&
                         (xs >= xb - HALF) && (xs <= xb + HALF_M1) &&
                         (ys >= yb - HALF) && (ys <= yb + HALF_M1);
endmodule

// File: tb/tb_ball_ctrl.sv
// Random paddle/pixel stimulus against a game-level model of the ball,
// plus fixed expectations for reset, serve timing, win and mid-rally reset.
module tb_ball_ctrl;
  localparam int HA = 640, VA = 480, BS = 8, SD = 1000, WS = 9;
  localparam int HB = BS / 2;
  localparam int REACH = 16 / 2 + 1;
  localparam int SPAN = (80 + BS) / 2;
  localparam int XP1 = 28, XP2 = 611;

  localparam int WAITING = 0, RALLY = 1, SCORED = 2, FINISHED = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ball_ctrl_if bus();

  ball_ctrl #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .BALL_SIZE(BS),
    .SERVE_DELAY(SD), .WIN_SCORE(WS)
  ) dut (
    .clk_1ms (clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  int phase, waited, bx, by, vx, vy, scorer;
  int sc[2];
  int px, py, yp1, yp2;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step(input bit r);
    if (r) begin
      phase = WAITING; waited = 0;
      bx = HA / 2; by = VA / 2; vx = 1; vy = 1;
      sc[0] = 0; sc[1] = 0;
      return;
    end
    case (phase)
      WAITING: begin
        waited++;
        if (waited == SD) begin waited = 0; phase = RALLY; end
      end
      RALLY: begin
        if (bx - HB == 0 && vx < 0) begin scorer = 1; phase = SCORED; end
        else if (bx + HB == HA - 1 && vx > 0) begin scorer = 0; phase = SCORED; end
        else begin
          if ((by - HB == 0 && vy < 0) || (by + HB == VA - 1 && vy > 0)) vy = -vy;
          if (vx < 0 && bx - HB == XP1 + REACH && absi(by - yp1) < SPAN) vx = 1;
          else if (vx > 0 && bx + HB == XP2 - REACH && absi(by - yp2) < SPAN) vx = -1;
          bx += vx; by += vy;
        end
      end
      SCORED: begin
        if (sc[scorer] < WS) sc[scorer]++;
        vx = (scorer == 0) ? 1 : -1;
        vy = -vy;
        bx = HA / 2; by = VA / 2;
        phase = (sc[scorer] == WS) ? FINISHED : WAITING;
      end
      default: ;
    endcase
  endtask

  task automatic drive_random();
    if ($urandom_range(1) == 0) begin
      px = clampi(bx + int'($urandom_range(12)) - 6, 0, 1023);
      py = clampi(by + int'($urandom_range(12)) - 6, 0, 1023);
    end else begin
      px = int'($urandom_range(HA - 1));
      py = int'($urandom_range(VA - 1));
    end
    yp1 = clampi(by + int'($urandom_range(200)) - 100, 0, VA - 1);
    yp2 = clampi(by + int'($urandom_range(200)) - 100, 0, VA - 1);
    bus.x = 10'(px); bus.y = 10'(py);
    bus.x_paddle1 = 10'(XP1); bus.y_paddle1 = 10'(yp1);
    bus.x_paddle2 = 10'(XP2); bus.y_paddle2 = 10'(yp2);
  endtask

  task automatic cycle(input bit r);
    rst = r;
    drive_random();
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("x_ball", int'(bus.x_ball), bx);
      chk("y_ball", int'(bus.y_ball), by);
      chk("score1", int'(bus.score1), sc[0]);
      chk("score2", int'(bus.score2), sc[1]);
      chk("game_over", int'(bus.game_over), int'(phase == FINISHED));
      chk("ball_on", int'(bus.ball_on),
          int'(phase != FINISHED && px >= bx - HB && px <= bx + HB - 1 &&
               py >= by - HB && py <= by + HB - 1));
      chk("rgb_ball", int'(bus.rgb_ball), 12'hFFF);
    end
  end

  initial begin
    int budget;
    cycle(1'b1);
    chk_en = 1'b1;
    chk("rst_x", int'(bus.x_ball), 320);
    chk("rst_y", int'(bus.y_ball), 240);
    chk("rst_s1", int'(bus.score1), 0);
    chk("rst_go", int'(bus.game_over), 0);

    for (int i = 0; i < SD; i++) cycle(1'b0);
    chk("serve_hold_x", int'(bus.x_ball), 320);
    cycle(1'b0);
    chk("first_move_x", int'(bus.x_ball), 321);
    chk("first_move_y", int'(bus.y_ball), 241);

    budget = 75000;
    while (phase != FINISHED && budget > 0) begin
      cycle(1'b0);
      budget--;
    end
    chk("reached_over", int'(bus.game_over), 1);
    chk("win_score", (bus.score1 > bus.score2) ? int'(bus.score1) : int'(bus.score2), 9);

    for (int i = 0; i < 50; i++) cycle(1'b0);
    chk("over_hold_go", int'(bus.game_over), 1);

    cycle(1'b1);
    chk("over_rst_s1", int'(bus.score1), 0);
    chk("over_rst_s2", int'(bus.score2), 0);
    chk("over_rst_go", int'(bus.game_over), 0);

    for (int i = 0; i < SD + 300; i++) cycle(1'b0);
    cycle(1'b1);
    chk("mid_rst_x", int'(bus.x_ball), 320);
    chk("mid_rst_y", int'(bus.y_ball), 240);
    for (int i = 0; i < SD; i++) cycle(1'b0);
    chk("restart_hold_x", int'(bus.x_ball), 320);
    cycle(1'b0);
    chk("restart_move_x", int'(bus.x_ball), 321);
    chk("restart_move_y", int'(bus.y_ball), 241);

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
